// File: rtl/gate_bist.sv
// gate_bist: self-test sequencer for a two-input AND/OR/NOT gate block.
// Optional build macro GATE_BIST_LOOP_EN: back-to-back sweeps with accumulated, saturating error state.
`default_nettype none

module gate_bist #(
    parameter int HOLD_CYCLES   = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iStart,
    input  logic       iAnd,
    input  logic       iOr,
    input  logic       iNot,
    output logic       oA,
    output logic       oB,
    output logic       oBusy,
    output logic       oDone,
    output logic       oPass,
    output logic [2:0] oErrCnt,
    output logic [1:0] oFailVec,
    output logic [2:0] oFailBits
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] SETTLE_AT = 8'(SETTLE_CYCLES);

    state_t     state;
    logic [1:0] vec;
    logic [1:0] vec_next;
    logic [7:0] cnt;
    logic [2:0] mismatch;
    logic       hit;
    logic [2:0] err_next;

    // oA/oB always equal the vector under test while in DRIVE, so they form the expected values
    assign mismatch = {iAnd ^ (oA & oB), iOr ^ (oA | oB), iNot ^ ~oA};
    assign hit      = (state == DRIVE) && (cnt == SETTLE_AT) && (mismatch != 3'b000);
    assign vec_next = vec + 2'd1;

    always_comb begin
        err_next = oErrCnt;
        if (hit) begin
`ifdef GATE_BIST_LOOP_EN
            err_next = (oErrCnt == 3'd7) ? 3'd7 : oErrCnt + 3'd1;
`else
            err_next = oErrCnt + 3'd1;
`endif
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state     <= IDLE;
            vec       <= 2'd0;
            cnt       <= 8'd0;
            oA        <= 1'b0;
            oB        <= 1'b0;
            oBusy     <= 1'b0;
            oDone     <= 1'b0;
            oPass     <= 1'b0;
            oErrCnt   <= 3'd0;
            oFailVec  <= 2'd0;
            oFailBits <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    oA    <= 1'b0;
                    oB    <= 1'b0;
                    oBusy <= 1'b0;
                    if (iStart) begin
                        state     <= DRIVE;
                        vec       <= 2'd0;
                        cnt       <= 8'd0;
                        oBusy     <= 1'b1;
                        oDone     <= 1'b0;
                        oPass     <= 1'b0;
                        oErrCnt   <= 3'd0;
                        oFailVec  <= 2'd0;
                        oFailBits <= 3'd0;
                    end
                end
                DRIVE: begin
                    cnt     <= cnt + 8'd1;
                    oErrCnt <= err_next;
                    // oErrCnt==0 marks the first failure since the last clear
                    if (hit && (oErrCnt == 3'd0)) begin
                        oFailVec  <= vec;
                        oFailBits <= mismatch;
                    end
                    if (cnt == HOLD_LAST) begin
                        cnt <= 8'd0;
                        if (vec == 2'd3) begin
                            state <= DONE;
                            oA    <= 1'b0;
                            oB    <= 1'b0;
                            oBusy <= 1'b0;
                            oDone <= 1'b1;
                            oPass <= (err_next == 3'd0);
                        end else begin
                            vec <= vec_next;
                            oA  <= vec_next[1];
                            oB  <= vec_next[0];
                        end
                    end
                end
                DONE: begin
                    if (iStart) begin
                        state <= DRIVE;
                        vec   <= 2'd0;
                        cnt   <= 8'd0;
                        oBusy <= 1'b1;
                        oDone <= 1'b0;
                        oPass <= 1'b0;
`ifndef GATE_BIST_LOOP_EN
                        oErrCnt   <= 3'd0;
                        oFailVec  <= 2'd0;
                        oFailBits <= 3'd0;
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_gate_bist.sv
// tb_gate_bist: directed self-checking bench for gate_bist with a fault-injectable gate model.
`default_nettype none

module tb_gate_bist;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       g_and, g_or, g_not;
    logic       a, b, busy, done, pass;
    logic [2:0] err_cnt;
    logic [1:0] fail_vec;
    logic [2:0] fail_bits;

    logic and_sa0, or_sa1, not_sa1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    // Gate block model with stuck-at faults
    always_comb begin
        g_and = and_sa0 ? 1'b0 : (a & b);
        g_or  = or_sa1  ? 1'b1 : (a | b);
        g_not = not_sa1 ? 1'b1 : ~a;
    end

    gate_bist #(.HOLD_CYCLES(4), .SETTLE_CYCLES(1)) dut (
        .iClk(clk), .iRst(rst), .iStart(start),
        .iAnd(g_and), .iOr(g_or), .iNot(g_not),
        .oA(a), .oB(b), .oBusy(busy), .oDone(done), .oPass(pass),
        .oErrCnt(err_cnt), .oFailVec(fail_vec), .oFailBits(fail_bits)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // After the start edge: check the 16 DRIVE cycles, then the DONE results
    task automatic run_sweep(input string name, input logic [2:0] exp_err,
                             input logic [1:0] exp_vec, input logic [2:0] exp_bits,
                             input logic hold_start);
        for (int i = 0; i < 16; i++) begin
            logic [1:0] ev;
            ev = 2'(i / 4);
            tests++;
            if (busy !== 1'b1 || done !== 1'b0 || {a, b} !== ev) begin
                fails++;
                $display("FAIL %s drive[%0d]: busy=%b done=%b ab=%b, required busy=1 done=0 ab=%b",
                         name, i, busy, done, {a, b}, ev);
            end
            if (hold_start && i == 15) start = 1'b0;
            tick();
        end
        tests++;
        if (done !== 1'b1 || busy !== 1'b0 || {a, b} !== 2'b00 || pass !== (exp_err == 3'd0) ||
            err_cnt !== exp_err || fail_vec !== exp_vec || fail_bits !== exp_bits) begin
            fails++;
            $display("FAIL %s result: done=%b busy=%b ab=%b pass=%b err=%0d vec=%0d bits=%b, required done=1 busy=0 ab=00 pass=%b err=%0d vec=%0d bits=%b",
                     name, done, busy, {a, b}, pass, err_cnt, fail_vec, fail_bits,
                     (exp_err == 3'd0), exp_err, exp_vec, exp_bits);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tests++;
        if ({a, b, busy, done, pass, err_cnt, fail_vec, fail_bits} !== 13'd0) begin
            fails++;
            $display("FAIL reset_state: outputs=%b, required all zero",
                     {a, b, busy, done, pass, err_cnt, fail_vec, fail_bits});
        end
        tick();
        tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL idle_hold: busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_clean();
        pulse_start();
        run_sweep("clean", 3'd0, 2'd0, 3'b000, 1'b0);
        // Results must hold while iStart stays low
        for (int i = 0; i < 3; i++) tick();
        tests++;
        if (done !== 1'b1 || pass !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL clean_hold: done=%b pass=%b busy=%b, required 1 1 0", done, pass, busy);
        end
    endtask

    task automatic test_and_stuck();
        and_sa0 = 1'b1;
        pulse_start();
        run_sweep("and_sa0", 3'd1, 2'd3, 3'b100, 1'b0);
        and_sa0 = 1'b0;
    endtask

    task automatic test_not_stuck();
        not_sa1 = 1'b1;
        pulse_start();
        run_sweep("not_sa1", 3'd2, 2'd2, 3'b001, 1'b0);
        not_sa1 = 1'b0;
    endtask

    task automatic test_reset_mid();
        pulse_start();
        for (int i = 0; i < 6; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if ({a, b, busy, done, pass, err_cnt, fail_vec, fail_bits} !== 13'd0) begin
            fails++;
            $display("FAIL reset_mid: outputs=%b, required all zero",
                     {a, b, busy, done, pass, err_cnt, fail_vec, fail_bits});
        end
        tick();
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_idle: busy=%b, required 0", busy);
        end
        pulse_start();
        run_sweep("after_reset", 3'd0, 2'd0, 3'b000, 1'b0);
    endtask

    task automatic test_start_held();
        logic [2:0] exp_err;
        logic [1:0] exp_vec;
        logic [2:0] exp_bits;
        not_sa1 = 1'b1;
        start = 1'b1;
        tick();
        // iStart stays high for the whole DRIVE phase and is dropped before DONE
        run_sweep("start_held", 3'd2, 2'd2, 3'b001, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++;
            if (done !== 1'b1 || busy !== 1'b0 || err_cnt !== 3'd2) begin
                fails++;
                $display("FAIL held_done[%0d]: done=%b busy=%b err=%0d, required 1 0 2",
                         i, done, busy, err_cnt);
            end
        end
        not_sa1 = 1'b0;
`ifdef GATE_BIST_LOOP_EN
        exp_err = 3'd2; exp_vec = 2'd2; exp_bits = 3'b001;
`else
        exp_err = 3'd0; exp_vec = 2'd0; exp_bits = 3'b000;
`endif
        pulse_start();
        tests++;
        if (busy !== 1'b1 || done !== 1'b0 || err_cnt !== exp_err) begin
            fails++;
            $display("FAIL restart_edge: busy=%b done=%b err=%0d, required 1 0 %0d",
                     busy, done, err_cnt, exp_err);
        end
        run_sweep("restart", exp_err, exp_vec, exp_bits, 1'b0);
    endtask

`ifdef GATE_BIST_LOOP_EN
    task automatic test_loop();
        int  n_done;
        logic prev;
        n_done = 0;
        prev = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        or_sa1 = 1'b1;
        start = 1'b1;
        tick();
        for (int i = 0; i < 60 && n_done < 3; i++) begin
            if (done === 1'b1) begin
                n_done++;
                tests++;
                if (prev === 1'b1) begin
                    fails++;
                    $display("FAIL loop_pulse: done high 2 cycles, required 1-cycle pulse");
                end
                if (n_done == 3) start = 1'b0;
            end
            prev = done;
            if (n_done < 3) tick();
        end
        tests++;
        if (n_done != 3 || done !== 1'b1 || err_cnt !== 3'd3 || fail_vec !== 2'd0 ||
            fail_bits !== 3'b010 || pass !== 1'b0) begin
            fails++;
            $display("FAIL loop_result: n_done=%0d done=%b err=%0d vec=%0d bits=%b pass=%b, required 3 1 3 0 010 0",
                     n_done, done, err_cnt, fail_vec, fail_bits, pass);
        end
        tick();
        tests++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL loop_stop: done=%b busy=%b, required 1 0", done, busy);
        end
        or_sa1 = 1'b0;
    endtask
`endif

    initial begin
        rst = 1'b0;
        start = 1'b0;
        and_sa0 = 1'b0;
        or_sa1 = 1'b0;
        not_sa1 = 1'b0;
        #2;
        test_reset();
        test_clean();
        test_and_stuck();
        test_not_stuck();
        test_reset_mid();
        test_start_held();
`ifdef GATE_BIST_LOOP_EN
        test_loop();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
